sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares the single read/write port (port 0) of the team's `sram` macro between two requesters.
  - Requester A: instruction fetch, read-only.
  - Requester B: load/store, read/write with byte mask.
- Valid/ready request and response handshakes per requester; one access in flight; round-robin or fixed priority.
- Sits between the core's fetch/LSU and the `sram` instance. Drives csb0/web0/wmask0/addr0/din0 and returns dout0.

Parameters:
- DATA_WIDTH, 32, word width; must equal the sram DATA_WIDTH.
- ADDR_WIDTH, 14, word address width; must equal the sram ADDR_WIDTH.
- NUM_WMASKS, 4, byte-mask width (DATA_WIDTH/8).
- FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = B always wins ties.

Ports:
- clk  in  1  single clock; also drives sram clk0.
- rst_n  in  1  asynchronous reset, active low.
- a_req_valid  in  1  fetch request valid.
- a_req_ready  out  1  fetch request accepted this cycle.
- a_req_addr  in  ADDR_WIDTH  fetch word address.
- a_rsp_valid  out  1  fetch read data valid.
- a_rsp_ready  in  1  fetch response consumed.
- a_rsp_rdata  out  DATA_WIDTH  fetch read data.
- b_req_valid  in  1  LSU request valid.
- b_req_ready  out  1  LSU request accepted.
- b_req_we  in  1  1 = write, 0 = read.
- b_req_wmask  in  NUM_WMASKS  byte enables for writes.
- b_req_addr  in  ADDR_WIDTH  LSU word address.
- b_req_wdata  in  DATA_WIDTH  write data.
- b_rsp_valid  out  1  LSU response valid (read data, or write ack).
- b_rsp_ready  in  1  LSU response consumed.
- b_rsp_rdata  out  DATA_WIDTH  LSU read data; 0 for write acks.
- sram_csb  out  1  to sram csb0, active low.
- sram_web  out  1  to sram web0, active low.
- sram_wmask  out  NUM_WMASKS  to sram wmask0.
- sram_addr  out  ADDR_WIDTH  to sram addr0.
- sram_din  out  DATA_WIDTH  to sram din0.
- sram_dout  in  DATA_WIDTH  from sram dout0.
- stall_cnt  out  16  saturating count of cycles where any req_valid=1 and its req_ready=0.

Behaviour:
- State registers:
  - rsp_pend (1b): a response is outstanding.
  - rsp_owner (A/B): which requester owns it.
  - rsp_wr (1b): the outstanding access is a write.
  - rr_last (A/B): last requester granted.
  - stall_cnt (16b).
- can_issue = !rsp_pend | (owner's rsp_valid & owner's rsp_ready), so back-to-back issue is possible at 1 access/cycle.
- Grant (combinational), only when can_issue:
  - Only one requester valid: grant it.
  - Both valid, FIXED_PRIO=0: grant the one != rr_last.
  - Both valid, FIXED_PRIO=1: grant B.
- x_req_ready = can_issue & grant==x. Ready may depend on the other requester's valid. issue = granted valid & ready.
- SRAM pins are combinational from the grantee; the sram registers them at posedge clk.
  - issue=1: sram_csb=0; sram_web = !(grant B & b_req_we); sram_wmask = b_req_wmask if B write, else 0; sram_addr = grantee addr; sram_din = b_req_wdata.
  - No issue: sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0.
- Issue edge: rsp_pend<=1, rsp_owner<=grantee, rsp_wr<=(B & we), rr_last<=grantee.
- If the response is accepted with no new issue, rsp_pend<=0.
- Response timing:
  - Latency: response is valid in the cycle after issue (N+1) and is held until accepted.
  - x_rsp_valid = rsp_pend & rsp_owner==x.
  - Read: rdata = sram_dout, passed through. dout0 is stable from mid-cycle N+1 until a later read's negedge, because no new access reaches the sram before the response is accepted.
  - Write: b_rsp_rdata=0. Non-owner and idle rdata = 0.
  - sram DELAY must be < half clock period.
- Fairness: with FIXED_PRIO=0, a continuously valid requester is granted within 2 issues. With FIXED_PRIO=1, A may starve; stall_cnt exposes this.
- stall_cnt: +1 per cycle where (a_req_valid & !a_req_ready) | (b_req_valid & !b_req_ready). Saturates at 0xFFFF; no wrap.
- Reset values while rst_n=0, asynchronous:
  - rsp_pend=0, rr_last=B (so A wins the first tie), stall_cnt=0.
  - Both req_ready=0, both rsp_valid=0, both rdata=0.
  - sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0.
- Reset mid-operation:
  - A pending response is dropped, never delivered.
  - A write the sram already sampled still completes at its negedge; it is not rolled back.
  - The first issue is possible in the first cycle after rst_n deasserts.
- Requesters must hold req fields stable while valid & !ready. A requester must not drop valid before ready.

Test Plan:
- Single read, fully exercising the datapath:
  - Preload mem[0x10]=0xDEADBEEF; A reads 0x10 at cycle N.
  - Expect sram_csb=0/web=1/addr=0x10 in N; a_rsp_valid=1, rdata=0xDEADBEEF in N+1.
- Byte-masked write then read:
  - B writes 0x11223344 mask 4'b0101 to 0x20 (old value 0xFFFFFFFF).
  - Expect b_rsp_valid=1, rdata=0 next cycle.
  - Then B reads 0x20 -> 0xFF22FF44.
- Simultaneous requests, FIXED_PRIO=0, both held valid 4 issues:
  - Grant order A,B,A,B; each response 1 cycle after its issue.
  - stall_cnt increments by 1 each cycle.
- Response backpressure:
  - A read with a_rsp_ready=0 for 3 cycles, B valid throughout.
  - Expect b_req_ready=0 and sram_csb=1 for those 3 cycles; a_rsp_rdata stable.
  - B issues in the cycle a_rsp_ready=1.
- FIXED_PRIO=1 starvation/saturation:
  - B valid every cycle with rsp_ready=1, A valid 70000 cycles.
  - Expect A never granted and stall_cnt == 0xFFFF (no wrap).
- Reset mid-response:
  - Assert rst_n=0 while a_rsp_valid=1.
  - Expect immediate a_rsp_valid=0, sram_csb=1, stall_cnt=0.
  - After release, a tie is granted to A first.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Arbitrates the single read/write port of the sram macro between instruction
// fetch (A, read-only) and load/store (B, masked read/write), one access in flight.
module sram_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_WMASKS = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Fetch requester
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  output logic                  a_rsp_valid,
  input  logic                  a_rsp_ready,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  // Load/store requester
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [NUM_WMASKS-1:0] b_req_wmask,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  input  logic                  b_rsp_ready,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  // sram port 0
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  // Observability
  output logic [15:0]           stall_cnt
);

  // Handshake rule for every channel: a transfer happens on the rising edge
  // where valid & ready are both 1. A requester holds valid and its payload
  // stable until ready; req_ready may depend on the other requester's valid,
  // and a response is held (valid and data) until its rsp_ready is seen.

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  logic    rsp_pend;
  req_id_t rsp_owner;
  logic    rsp_wr;
  req_id_t rr_last;
  logic    can_issue;
  logic    gnt_a;
  logic    gnt_b;
  logic    issue;
  logic    rsp_done;
  logic    b_write;
  logic    stall_ev;

  // Response side: the owner sees valid; read data passes straight from dout.
  always_comb begin
    a_rsp_valid = rsp_pend && (rsp_owner == REQ_A);
    b_rsp_valid = rsp_pend && (rsp_owner == REQ_B);
    a_rsp_rdata = a_rsp_valid ? sram_dout : '0;
    b_rsp_rdata = (b_rsp_valid && !rsp_wr) ? sram_dout : '0;
    rsp_done    = (a_rsp_valid && a_rsp_ready) || (b_rsp_valid && b_rsp_ready);
  end

  // rst_n gating keeps readies and the sram idle for the whole reset window.
  always_comb begin
    can_issue = rst_n && (!rsp_pend || rsp_done);
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    if (can_issue) begin
      if (a_req_valid && b_req_valid) begin
        if (FIXED_PRIO || (rr_last == REQ_A)) gnt_b = 1'b1;
        else                                  gnt_a = 1'b1;
      end else begin
        gnt_a = a_req_valid;
        gnt_b = b_req_valid;
      end
    end
    a_req_ready = gnt_a;
    b_req_ready = gnt_b;
    issue       = gnt_a || gnt_b;
    b_write     = gnt_b && b_req_we;
  end

  // sram pins: the macro registers these on the rising edge that issues.
  always_comb begin
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (issue) begin
      sram_csb   = 1'b0;
      sram_web   = !b_write;
      sram_wmask = b_write ? b_req_wmask : '0;
      sram_addr  = gnt_b ? b_req_addr : a_req_addr;
      sram_din   = b_req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend  <= 1'b0;
      rsp_owner <= REQ_A;
      rsp_wr    <= 1'b0;
      rr_last   <= REQ_B;
    end else if (issue) begin
      rsp_pend  <= 1'b1;
      rsp_owner <= gnt_b ? REQ_B : REQ_A;
      rsp_wr    <= b_write;
      rr_last   <= gnt_b ? REQ_B : REQ_A;
    end else if (rsp_done) begin
      rsp_pend  <= 1'b0;
    end
  end

  // Cycles where some requester waits; saturates so starvation stays visible.
  always_comb begin
    stall_ev = (a_req_valid && !a_req_ready) || (b_req_valid && !b_req_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_ev && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
